// File: rtl/div_sequencer.sv
// Signed sequential divider using one non-restoring step per clock.
// Handshake: start is accepted on a rising edge only when busy is low
// (IDLE or DONE). The operands are captured on that edge. done then pulses
// for one cycle, and q, r and div_zero are valid in that cycle. They hold
// their values until the next result is registered.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d;       // partial remainder, one guard bit
    logic [WIDTH-1:0] qw_q, qw_d;     // working quotient, starts as |dividend|
    logic [WIDTH:0]   m_q, m_d;       // |divisor|, widened
    logic             sq_q, sq_d;     // quotient must be negated
    logic             sr_q, sr_d;     // remainder must be negated
    logic             dzm_q, dzm_d;   // current operation divides by zero
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH:0]   a_shift, a_step, a_fix;
    logic [WIDTH-1:0] qw_step, q_signed, r_mag, r_signed;

    // Datapath: operand magnitudes, one non-restoring step and the final sign fix-up.
    always_comb begin
        abs_dvd  = dividend[WIDTH-1] ? (-dividend) : dividend;
        abs_dvs  = divisor[WIDTH-1] ? (-divisor) : divisor;
        a_shift  = {a_q[WIDTH-1:0], qw_q[WIDTH-1]};
        a_step   = a_q[WIDTH] ? (a_shift + m_q) : (a_shift - m_q);
        qw_step  = {qw_q[WIDTH-2:0], ~a_step[WIDTH]};
        a_fix    = a_q[WIDTH] ? (a_q + m_q) : a_q;
        q_signed = sq_q ? (-qw_q) : qw_q;
        // On divide-by-zero the quotient register still holds |dividend|.
        // Re-applying the dividend sign to it gives back the dividend.
        r_mag    = dzm_q ? qw_q : a_fix[WIDTH-1:0];
        r_signed = sr_q ? (-r_mag) : r_mag;
    end

    // Next-state, datapath loads and status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        qw_d    = qw_q;
        m_d     = m_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dzm_d   = dzm_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dz_d    = dz_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            RUN: begin
                busy  = 1'b1;
                a_d   = a_step;
                qw_d  = qw_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                a_d     = a_fix;
                q_out_d = dzm_q ? {WIDTH{1'b1}} : q_signed;
                r_out_d = r_signed;
                dz_d    = dzm_q;
                state_d = DONE;
            end
            default: begin  // IDLE and DONE both accept a new start
                done = (state_q == DONE);
                if (start) begin
                    qw_d  = abs_dvd;
                    m_d   = {1'b0, abs_dvs};
                    a_d   = '0;
                    cnt_d = CNT_INIT;
                    sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sr_d  = dividend[WIDTH-1];
                    if (divisor == '0) begin
                        dzm_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        dzm_d   = 1'b0;
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            qw_q    <= '0;
            m_q     <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dzm_q   <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            qw_q    <= qw_d;
            m_q     <= m_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dzm_q   <= dzm_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dz_q    <= dz_d;
        end
    end

    assign q         = q_out_q;
    assign r         = r_out_q;
    assign div_zero  = dz_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer. Directed cases plus randomized signed divisions,
// checked by a queue-based scoreboard against a plain-arithmetic model.
module tb_div_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [2*W:0] exp_q[$];      // {div_zero, q, r}
    int           exp_cyc_q[$];  // edge count at which done is expected

    div_sequencer #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // Clock and edge counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Truncating signed division computed with 64-bit arithmetic.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] qq;
        logic signed [63:0] rr;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        if (b == '0) begin
            return {1'b1, {W{1'b1}}, a};
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, qq[W-1:0], rr[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 300));
            5:       return -32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    // Driver: presents operands with start, waits for the accepting edge and
    // records the expected result and completion edge.
    task automatic start_op_x(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W:0] exp);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + ((b == '0) ? 1 : W + 1));
        start = 1'b0;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_op_x(a, b, model(a, b));
    endtask

    // Waits for done (bounded) while counting busy cycles.
    task automatic wait_done(input int exp_busy);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
        end
        checks++;
        if (!seen || n != exp_busy) begin
            errors++;
            $display("FAIL busy_window: done_seen=%0b busy_cycles=%0d required done_seen=1 busy_cycles=%0d",
                     seen, n, exp_busy);
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({busy, done, q, r, div_zero} != '0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b q=%h r=%h dz=%0b required all zero",
                     name, busy, done, q, r, div_zero);
        end
    endtask

    // Monitor: every done pulse pops and checks one expectation.
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        logic [2*W:0] e;
        int           ec;
        if (done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: done high on consecutive cycles at edge %0d", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: q=%h r=%h dz=%0b at edge %0d with nothing pending",
                         q, r, div_zero, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if ({div_zero, q, r} != e) begin
                    errors++;
                    $display("FAIL result: got dz=%0b q=%h r=%h required dz=%0b q=%h r=%h",
                             div_zero, q, r, e[2*W], e[2*W-1:W], e[W-1:0]);
                end
                checks++;
                if (cyc != ec) begin
                    errors++;
                    $display("FAIL latency: done at edge %0d required edge %0d", cyc, ec);
                end
            end
        end
        prev_done <= done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_cleared("reset_state");
        clear = 1'b0;

        // Positive operands, also checks the 33-cycle busy window
        start_op_x(32'd100, 32'd7, {1'b0, 32'd14, 32'd2});
        wait_done(W + 1);
        @(negedge clock);

        // Signed combinations, issued back to back from the DONE cycle
        start_op_x(32'hFFFF_FF9C, 32'd7, {1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE});
        wait_done(W + 1);
        start_op_x(32'd100, 32'hFFFF_FFF9, {1'b0, 32'hFFFF_FFF2, 32'd2});
        wait_done(W + 1);
        start_op_x(32'hFFFF_FF9C, 32'hFFFF_FFF9, {1'b0, 32'd14, 32'hFFFF_FFFE});
        wait_done(W + 1);

        // Overflow wrap and most-negative by one
        start_op_x(32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h8000_0000, 32'd0});
        wait_done(W + 1);
        start_op_x(32'h8000_0000, 32'd1, {1'b0, 32'h8000_0000, 32'd0});
        wait_done(W + 1);
        @(negedge clock);

        // Zero divisor
        start_op_x(32'h1234_5678, 32'd0, {1'b1, 32'hFFFF_FFFF, 32'h1234_5678});
        wait_done(1);
        @(negedge clock);

        // Clear sampled on edge 10 of a division; no done may follow
        start_op(32'd100, 32'd7);
        repeat (8) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        @(posedge clock);
        #1;
        check_cleared("clear_mid_run");
        @(negedge clock);
        clear = 1'b0;
        start_op_x(32'd9, 32'd3, {1'b0, 32'd3, 32'd0});
        wait_done(W + 1);
        @(negedge clock);

        // start held during RUN with changing operands must be ignored
        start_op_x(32'd1000, 32'd33, {1'b0, 32'd30, 32'd10});
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            @(negedge clock);
        end
        start = 1'b0;
        wait_done(W + 1 - 5);

        // Randomized traffic, mixing back-to-back and idle-separated starts
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = rand_operand();
            b = rand_operand();
            start_op(a, b);
            wait_done((b == '0) ? 1 : W + 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_at_end: %0d results outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
